// File: rtl/bscan_chain_driver.sv
// Boundary-scan chain master: runs one capture/shift/update sequence per host
// command, serializing the write vector onto bs_sdo and collecting bs_sdi.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; only state with cmd_ready high
// CAPTURE | one cycle, chain cells load pad values
// SHIFT   | CHAIN_LEN cycles, wdata out on bs_sdo, bs_sdi into cap_data
// UPDATE  | one-cycle update strobe (PRELOAD / EXTEST only)
// DONE    | rsp_valid held until the host takes the response
module bscan_chain_driver #(
  parameter  int CHAIN_LEN = 39,
  localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 tclk,
  input  logic                 r,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] cap_data,
  output logic                 bs_sdo,
  input  logic                 bs_sdi,
  output logic                 bs_en,
  output logic                 shift,
  output logic                 update,
  output logic                 mode,
  output logic                 hiz_b
);

  localparam logic [1:0] OP_SAMPLE  = 2'b00;
  localparam logic [1:0] OP_PRELOAD = 2'b01;
  localparam logic [1:0] OP_EXTEST  = 2'b10;
  localparam logic [1:0] OP_HIGHZ   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t               r_state, w_state;
  logic [1:0]           r_op, w_op;
  logic [CHAIN_LEN-1:0] r_sr, w_sr;
  logic [CHAIN_LEN-1:0] r_cap, w_cap;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic                 r_sdo, w_sdo;
  logic                 r_en, w_en;
  logic                 r_shift, w_shift;
  logic                 r_update, w_update;
  logic                 r_mode, w_mode;
  logic                 r_hizb, w_hizb;
  logic                 r_rsp, w_rsp;
  logic                 w_last;

  assign w_last    = (r_cnt == CNT_W'(CHAIN_LEN - 1));
  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp;
  assign cap_data  = r_cap;
  assign bs_sdo    = r_sdo;
  assign bs_en     = r_en;
  assign shift     = r_shift;
  assign update    = r_update;
  assign mode      = r_mode;
  assign hiz_b     = r_hizb;

  always_ff @(posedge tclk or posedge r) begin
    if (r) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge tclk or posedge r) begin
    if (r) begin
      r_op     <= OP_SAMPLE;
      r_sr     <= '0;
      r_cap    <= '0;
      r_cnt    <= '0;
      r_sdo    <= 1'b0;
      r_en     <= 1'b0;
      r_shift  <= 1'b0;
      r_update <= 1'b0;
      r_mode   <= 1'b0;
      r_hizb   <= 1'b1;
      r_rsp    <= 1'b0;
    end else begin
      r_op     <= w_op;
      r_sr     <= w_sr;
      r_cap    <= w_cap;
      r_cnt    <= w_cnt;
      r_sdo    <= w_sdo;
      r_en     <= w_en;
      r_shift  <= w_shift;
      r_update <= w_update;
      r_mode   <= w_mode;
      r_hizb   <= w_hizb;
      r_rsp    <= w_rsp;
    end
  end

  // Outputs are registered, so each one is set on the edge entering the cycle it belongs to.
  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_sr     = r_sr;
    w_cap    = r_cap;
    w_cnt    = r_cnt;
    w_sdo    = r_sdo;
    w_en     = r_en;
    w_shift  = r_shift;
    w_update = r_update;
    w_mode   = r_mode;
    w_hizb   = r_hizb;
    w_rsp    = r_rsp;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op   = cmd_op;
          w_sr   = cmd_wdata;
          w_mode = (cmd_op == OP_EXTEST) ? r_mode : 1'b0;
          w_hizb = (cmd_op != OP_HIGHZ);
          w_en   = 1'b1;
          if (cmd_op == OP_HIGHZ) begin
            w_state = S_DONE;
            w_rsp   = 1'b1;
          end else begin
            w_state = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        w_state = S_SHIFT;
        w_cnt   = '0;
        w_shift = 1'b1;
        w_sdo   = r_sr[0];
        w_sr    = r_sr >> 1;
      end

      S_SHIFT: begin
        w_cap[r_cnt] = bs_sdi;
        if (w_last) begin
          w_cnt   = '0;
          w_shift = 1'b0;
          w_sdo   = 1'b0;
          if (r_op == OP_SAMPLE) begin
            w_state = S_DONE;
            w_rsp   = 1'b1;
            w_en    = r_mode | ~r_hizb;
          end else begin
            w_state  = S_UPDATE;
            w_update = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
          w_sdo = r_sr[0];
          w_sr  = r_sr >> 1;
        end
      end

      S_UPDATE: begin
        w_state  = S_DONE;
        w_update = 1'b0;
        w_rsp    = 1'b1;
        w_mode   = (r_op == OP_EXTEST) ? 1'b1 : r_mode;
        w_en     = w_mode | ~r_hizb;
      end

      S_DONE: begin
        if (rsp_ready) begin
          w_state = S_IDLE;
          w_rsp   = 1'b0;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bscan_chain_driver.sv
// Bench for bscan_chain_driver: loopback or shift-register chain model on the
// serial side, command outcomes predicted from the per-op rules.
module tb_bscan_chain_driver;

  localparam int L = 39;
  localparam logic [1:0] OP_S = 2'b00;
  localparam logic [1:0] OP_P = 2'b01;
  localparam logic [1:0] OP_E = 2'b10;
  localparam logic [1:0] OP_H = 2'b11;

  logic         tclk = 1'b0;
  logic         r;
  logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]   cmd_op;
  logic [L-1:0] cmd_wdata, cap_data;
  logic         bs_sdo, bs_sdi, bs_en, shift, update, mode, hiz_b;

  int checks = 0;
  int errors = 0;

  logic         loopback;
  logic [L-1:0] chain, chain_init;
  logic         chain_load;
  logic [L-1:0] m_cap;
  logic         m_mode;

  int run_len = 0;
  bit abort_run = 0;

  bscan_chain_driver #(.CHAIN_LEN(L)) dut (
    .tclk(tclk), .r(r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .cap_data(cap_data),
    .bs_sdo(bs_sdo), .bs_sdi(bs_sdi), .bs_en(bs_en), .shift(shift),
    .update(update), .mode(mode), .hiz_b(hiz_b)
  );

  always #5 tclk = ~tclk;

  // Chain model: cell 0 sits next to sdo, new bits enter at the far end.
  assign bs_sdi = loopback ? bs_sdo : chain[0];
  always @(posedge tclk) begin
    if (chain_load) chain <= chain_init;
    else if (shift) chain <= {bs_sdo, chain[L-1:1]};
  end

  always @(negedge tclk) begin
    checks++;
    if (shift && update) begin
      errors++;
      $display("FAIL shift_update_overlap shift=%0b update=%0b required not both 1", shift, update);
    end
    if (shift) run_len++;
    else if (run_len != 0) begin
      if (!abort_run) begin
        checks++;
        if (run_len != L) begin
          errors++;
          $display("FAIL shift_run_length got %0d required %0d", run_len, L);
        end
      end
      run_len = 0;
      abort_run = 0;
    end
  end

  function automatic logic [L-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[L-1:0];
  endfunction

  task automatic load_chain(input logic [L-1:0] v);
    @(negedge tclk);
    chain_init = v;
    chain_load = 1'b1;
    @(negedge tclk);
    chain_load = 1'b0;
  endtask

  // Issues one command and measures what the DUT did; callers judge the results.
  task automatic do_cmd(input logic [1:0] op, input logic [L-1:0] wd, input int hold,
                        output int lat, output int n_upd, output int upd_cyc,
                        output int n_shift, output int held,
                        output logic [L-1:0] cap_s, output logic mode_s,
                        output logic hiz_s, output logic en_s, output logic rdy_s,
                        output logic mode_c1, output logic hiz_c1);
    int w;
    lat = 0; n_upd = 0; upd_cyc = -1; n_shift = 0; held = 0; w = 0;
    @(negedge tclk);
    while (!cmd_ready && w < 20) begin
      @(negedge tclk);
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    @(negedge tclk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_wdata = rand_vec();
    lat = 1;
    mode_c1 = mode;
    hiz_c1  = hiz_b;
    while (!rsp_valid && lat < 200) begin
      if (shift) n_shift++;
      if (update) begin n_upd++; upd_cyc = lat; end
      @(negedge tclk);
      lat++;
    end
    if (update) n_upd++;
    cap_s = cap_data; mode_s = mode; hiz_s = hiz_b; en_s = bs_en; rdy_s = cmd_ready;
    for (int i = 0; i < hold; i++) begin
      @(negedge tclk);
      if (rsp_valid && !cmd_ready) held++;
      if (update) n_upd++;
    end
    rsp_ready = 1'b1;
    @(negedge tclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, rsp_valid, bs_sdo, bs_en, shift, update, mode, hiz_b} !== 8'b1000_0001) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 10000001",
               {cmd_ready, rsp_valid, bs_sdo, bs_en, shift, update, mode, hiz_b});
    end
    checks++;
    if (cap_data !== '0) begin
      errors++;
      $display("FAIL reset_cap got %h required 0", cap_data);
    end
    @(negedge tclk);
    r = 1'b0;
    @(negedge tclk);
    checks++;
    if ({cmd_ready, bs_en, shift, update, mode, hiz_b} !== 6'b100001) begin
      errors++;
      $display("FAIL post_reset_ctrl got %b required 100001",
               {cmd_ready, bs_en, shift, update, mode, hiz_b});
    end
    m_cap = '0;
    m_mode = 1'b0;
  endtask

  task automatic test_loopback_sample();
    int lat, nu, uc, ns, hd;
    logic [L-1:0] cs;
    logic ms, hs, es, rs, m1, h1;
    loopback = 1'b1;
    do_cmd(OP_S, 39'h55_AAAA_5555, 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if (cs !== 39'h55_AAAA_5555) begin errors++; $display("FAIL sample_cap got %h required %h", cs, 39'h55_AAAA_5555); end
    checks++;
    if (lat != L + 2) begin errors++; $display("FAIL sample_latency got %0d required %0d", lat, L + 2); end
    checks++;
    if (nu != 0) begin errors++; $display("FAIL sample_update_count got %0d required 0", nu); end
    checks++;
    if (ns != L) begin errors++; $display("FAIL sample_shift_count got %0d required %0d", ns, L); end
    checks++;
    if ({ms, hs, es, rs} !== 4'b0100) begin errors++; $display("FAIL sample_done_ctrl got %b required 0100", {ms, hs, es, rs}); end
    m_cap = 39'h55_AAAA_5555;
    m_mode = 1'b0;
  endtask

  task automatic test_preload();
    int lat, nu, uc, ns, hd;
    logic [L-1:0] cs;
    logic ms, hs, es, rs, m1, h1;
    loopback = 1'b0;
    load_chain(39'h7F_0000_0001);
    do_cmd(OP_P, 39'h12_3456_789A, 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if (cs !== 39'h7F_0000_0001) begin errors++; $display("FAIL preload_cap got %h required %h", cs, 39'h7F_0000_0001); end
    checks++;
    if (chain !== 39'h12_3456_789A) begin errors++; $display("FAIL preload_chain got %h required %h", chain, 39'h12_3456_789A); end
    checks++;
    if (nu != 1 || uc != L + 2) begin errors++; $display("FAIL preload_update got count %0d at %0d required 1 at %0d", nu, uc, L + 2); end
    checks++;
    if (lat != L + 3) begin errors++; $display("FAIL preload_latency got %0d required %0d", lat, L + 3); end
    checks++;
    if ({ms, es} !== 2'b00) begin errors++; $display("FAIL preload_mode_en got %b required 00", {ms, es}); end
    m_cap = 39'h7F_0000_0001;
    m_mode = 1'b0;
  endtask

  task automatic test_extest_sample();
    int lat, nu, uc, ns, hd;
    logic [L-1:0] cs, wd;
    logic ms, hs, es, rs, m1, h1;
    loopback = 1'b1;
    wd = rand_vec();
    do_cmd(OP_E, wd, 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if ({ms, es} !== 2'b11) begin errors++; $display("FAIL extest_mode_en got %b required 11", {ms, es}); end
    checks++;
    if (cs !== wd || lat != L + 3) begin errors++; $display("FAIL extest_cap_lat got %h/%0d required %h/%0d", cs, lat, wd, L + 3); end
    wd = rand_vec();
    do_cmd(OP_S, wd, 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if (m1 !== 1'b0) begin errors++; $display("FAIL sample_clears_mode got %b required 0", m1); end
    checks++;
    if ({ms, es} !== 2'b00 || cs !== wd) begin errors++; $display("FAIL sample_after_extest got mode/en %b cap %h required 00 %h", {ms, es}, cs, wd); end
    m_cap = wd;
    m_mode = 1'b0;
  endtask

  task automatic test_highz();
    int lat, nu, uc, ns, hd;
    logic [L-1:0] cs;
    logic ms, hs, es, rs, m1, h1;
    loopback = 1'b1;
    do_cmd(OP_H, rand_vec(), 5, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL highz_latency got %0d required 1", lat); end
    checks++;
    if ({hs, es, rs} !== 3'b010) begin errors++; $display("FAIL highz_ctrl got %b required 010", {hs, es, rs}); end
    checks++;
    if (hd != 5) begin errors++; $display("FAIL highz_hold got %0d required 5", hd); end
    checks++;
    if (cs !== m_cap || ns != 0) begin errors++; $display("FAIL highz_cap got %h shifts %0d required %h 0", cs, ns, m_cap); end
    do_cmd(OP_P, rand_vec(), 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if ({h1, hs} !== 2'b11) begin errors++; $display("FAIL preload_restores_hizb got %b required 11", {h1, hs}); end
    m_cap = cs;
    m_mode = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat, nu, uc, ns, hd, cnt, w;
    logic [L-1:0] cs, wd;
    logic ms, hs, es, rs, m1, h1;
    loopback = 1'b1;
    do_cmd(OP_E, rand_vec(), 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    @(negedge tclk);
    cmd_valid = 1'b1; cmd_op = OP_E; cmd_wdata = rand_vec();
    @(negedge tclk);
    cmd_valid = 1'b0;
    cnt = 0; w = 0;
    while (cnt < 18 && w < 100) begin
      if (shift) cnt++;
      if (cnt < 18) begin @(negedge tclk); w++; end
    end
    checks++;
    if (cnt != 18) begin errors++; $display("FAIL reset_wait_shift got %0d required 18", cnt); end
    abort_run = 1;
    #2 r = 1'b1;
    #1;
    checks++;
    if ({shift, update, bs_en, hiz_b, mode, cmd_ready, rsp_valid} !== 7'b0001010) begin
      errors++;
      $display("FAIL reset_mid_shift got %b required 0001010",
               {shift, update, bs_en, hiz_b, mode, cmd_ready, rsp_valid});
    end
    @(negedge tclk);
    r = 1'b0;
    nu = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge tclk);
      if (update) nu++;
    end
    checks++;
    if (nu != 0) begin errors++; $display("FAIL reset_no_update got %0d required 0", nu); end
    wd = rand_vec();
    do_cmd(OP_S, wd, 0, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
    checks++;
    if (cs !== wd || lat != L + 2 || ns != L) begin
      errors++;
      $display("FAIL sample_after_reset got %h lat %0d shifts %0d required %h %0d %0d", cs, lat, ns, wd, L + 2, L);
    end
    m_cap = wd;
    m_mode = 1'b0;
  endtask

  task automatic test_random();
    int lat, nu, uc, ns, hd, hold;
    logic [L-1:0] cs, wd, ch0, e_cap;
    logic ms, hs, es, rs, m1, h1;
    logic [1:0] op;
    logic e_mode;
    for (int it = 0; it < 16; it++) begin
      op = 2'($urandom);
      wd = rand_vec();
      hold = int'($urandom_range(0, 3));
      loopback = 1'($urandom);
      ch0 = rand_vec();
      if (!loopback) load_chain(ch0);
      do_cmd(op, wd, hold, lat, nu, uc, ns, hd, cs, ms, hs, es, rs, m1, h1);
      e_mode = (op == OP_E);
      if (op == OP_H) e_cap = m_cap;
      else e_cap = loopback ? wd : ch0;
      checks++;
      if (lat != (op == OP_H ? 1 : (op == OP_S ? L + 2 : L + 3))) begin
        errors++; $display("FAIL rnd_latency op %0d got %0d", op, lat);
      end
      checks++;
      if (cs !== e_cap) begin errors++; $display("FAIL rnd_cap op %0d got %h required %h", op, cs, e_cap); end
      checks++;
      if (ms !== e_mode || hs !== (op != OP_H) || es !== (op == OP_E || op == OP_H)) begin
        errors++; $display("FAIL rnd_done_ctrl op %0d got mode %b hizb %b en %b", op, ms, hs, es);
      end
      checks++;
      if (m1 !== (op == OP_E ? m_mode : 1'b0) || h1 !== (op != OP_H)) begin
        errors++; $display("FAIL rnd_accept_ctrl op %0d got mode %b hizb %b", op, m1, h1);
      end
      checks++;
      if (nu != ((op == OP_P || op == OP_E) ? 1 : 0) || ns != (op == OP_H ? 0 : L)) begin
        errors++; $display("FAIL rnd_strobes op %0d got updates %0d shifts %0d", op, nu, ns);
      end
      checks++;
      if (hd != hold || rs !== 1'b0) begin errors++; $display("FAIL rnd_hold got %0d ready %b required %0d 0", hd, rs, hold); end
      if (!loopback) begin
        checks++;
        if (chain !== (op == OP_H ? ch0 : wd)) begin errors++; $display("FAIL rnd_chain got %h", chain); end
      end
      m_cap = e_cap;
      m_mode = e_mode;
    end
  endtask

  initial begin
    r = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'b00; cmd_wdata = '0;
    loopback = 1'b1; chain_load = 1'b0; chain_init = '0;
    repeat (3) @(negedge tclk);
    test_reset();
    test_loopback_sample();
    test_preload();
    test_extest_sample();
    test_highz();
    test_reset_mid_shift();
    test_random();
    repeat (3) @(negedge tclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bscan_chain_driver.md
Name: bscan_chain_driver

Overview:
Master-side driver for the IO-column boundary-scan chain. The IO columns hang on this chain as serial sdi->sdo cells, clocked on tclk and controlled by shift, update, bs_en, mode and hiz_b. This block accepts one command from a host-side handshake. It generates the capture/shift/update control sequence, serializes a write vector into the chain's sdi, and deserializes the chain's sdo into a capture vector. It sits in the JTAG/test controller, at the opposite end of the chain from the IO columns.

Parameters:
CHAIN_LEN, 39, number of boundary-scan cells in the chain (legal range 2..64)
CNT_W, $clog2(CHAIN_LEN), shift-counter width (derived; not overridden)

Ports:
tclk  input  1  scan clock; all state on rising edge
r  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  00 SAMPLE, 01 PRELOAD, 10 EXTEST, 11 HIGHZ
cmd_wdata  input  CHAIN_LEN  vector to shift in; bit 0 shifted first
rsp_valid  output  1  command complete; cap_data valid
rsp_ready  input  1  host accepts the response
cap_data  output  CHAIN_LEN  captured chain output; bit 0 = first bit received
bs_sdo  output  1  serial data to chain sdi
bs_sdi  input  1  serial data from chain sdo
bs_en  output  1  boundary-scan enable to IO columns
shift  output  1  chain shift enable
update  output  1  one-cycle update strobe
mode  output  1  1 = pads driven from update latches (EXTEST)
hiz_b  output  1  0 = all pads tristated

Behaviour:
- Reset values (async on r): state IDLE, cmd_ready=1, rsp_valid=0, cap_data=0, bs_sdo=0, bs_en=0, shift=0, update=0, mode=0, hiz_b=1, counter=0.
- All outputs are registered, with one exception: cmd_ready is decoded from the IDLE state.
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - A command is accepted on cmd_valid && cmd_ready.
  - On accept, latch cmd_wdata into the shift register and latch cmd_op.
  - On accept, clear mode to 0 unless op=EXTEST, and set hiz_b=1 unless op=HIGHZ.
  - HIGHZ: set hiz_b=0 and go directly to DONE; cap_data is left unchanged.
  - Other ops: bs_en=1, go to CAPTURE.
- CAPTURE: one cycle; shift=0, update=0. The chain cells load pad values. Next state is SHIFT with counter=0.
- SHIFT: exactly CHAIN_LEN cycles with shift=1.
  - In cycle k (k=0..CHAIN_LEN-1), bs_sdo = wdata[k].
  - At the end of cycle k, bs_sdi is stored into cap_data[k].
  - The counter wraps from CHAIN_LEN-1 to the next state.
  - SAMPLE goes to DONE. PRELOAD and EXTEST go to UPDATE.
- UPDATE: one cycle; update=1, shift=0, bs_sdo=0. For EXTEST, mode is set to 1 on exit. Next state is DONE.
- DONE:
  - rsp_valid=1; bs_en returns to 0 unless mode=1 or hiz_b=0, in which case it stays 1.
  - rsp_valid holds until rsp_ready; leave DONE on rsp_valid && rsp_ready.
  - cmd_ready=0 during DONE, so there is no back-to-back accept in the same cycle.
- Latency from accept to rsp_valid:
  - SAMPLE: CHAIN_LEN+2 cycles.
  - PRELOAD and EXTEST: CHAIN_LEN+3 cycles.
  - HIGHZ: 1 cycle.
- mode and hiz_b are sticky between commands and change only at the points stated above.
- cmd_wdata and cmd_op changing after accept have no effect.
- cap_data holds its last value until the next SHIFT overwrites it.
- Reset asserted mid-SHIFT or mid-UPDATE: all outputs go to their reset values immediately, with no update strobe emitted. The next command restarts from CAPTURE.
- shift and update are never high together. update is never high outside UPDATE.

Test Plan:
- Loopback bs_sdo->bs_sdi directly, SAMPLE with cmd_wdata=39'h55_AAAA_5555 -> cap_data == 39'h55_AAAA_5555, rsp_valid at accept+41 cycles, update never high.
- Chain model = 39-bit shift register preloaded 39'h7F_0000_0001, PRELOAD with wdata=39'h12_3456_789A -> cap_data == 39'h7F_0000_0001, model holds 39'h12_3456_789A, exactly one update pulse at cycle 41 after accept, mode stays 0.
- EXTEST, then SAMPLE -> mode=1 after the EXTEST UPDATE, and bs_en=1 in DONE. mode clears to 0 on the SAMPLE accept.
- HIGHZ, then rsp_ready held low 5 cycles -> hiz_b=0 and rsp_valid=1 from accept+1, held 5 cycles, cmd_ready=0 throughout. The next PRELOAD accept restores hiz_b=1.
- Assert r for 1 cycle at SHIFT count 17 -> shift=0, update=0, bs_en=0, hiz_b=1, mode=0, cmd_ready=1 immediately. No update pulse. A following SAMPLE completes normally.
- Assertion bench-wide: shift & update never both 1; shift is high exactly CHAIN_LEN consecutive cycles per non-HIGHZ command.
